wb_stage: RTL
=============

Name: wb_stage

Overview:
- MEM/WB pipeline boundary plus load-data extension for the RV32I pipeline.
- Registers the MEM-stage write-back control, destination and ALU result.
- Takes the synchronous data-cache read word one cycle after the address and sign/zero-extends it by load type.
- Drives write port 3 of the register file (A3/WD3/WE3) and the WB forwarding path; holds the cache word across stalls.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- stall_w  in  1  hold WB register contents (cache miss / hazard unit).
- flush_w  in  1  load bubble into WB register.
- reg_write_m  in  3  MEM-stage write type (package encoding).
- mem_to_reg_m  in  1  1 = result from memory, 0 = from ALU.
- rd_m  in  5  destination register.
- alu_out_m  in  32  ALU result / load address.
- dm_rdata  in  32  cache read word, valid the cycle after the address.
- A3  out  5  to register file.
- WD3  out  32  to register file.
- WE3  out  3  to register file; 0 = no write.
- fwd_valid_w  out  1  WE3!=0 and A3!=0.
- fwd_data_w  out  32  equals WD3.

Behaviour:
- WB register fields: reg_write_w[2:0], mem_to_reg_w, rd_w[4:0], alu_out_w[31:0], hold_valid, hold_data[31:0].
- Priority at each posedge: rst > flush_w > stall_w > load.
- rst or flush_w: all fields become 0; WE3=0, A3=0, WD3=0, fwd_valid_w=0 the next cycle.
- flush_w and stall_w both high: flush wins.
- stall_w high, flush_w low: all fields keep their values.
- On the first stalled cycle (hold_valid=0): capture dm_rdata into hold_data and set hold_valid=1.
- hold_valid clears on any non-stalled edge.
- Otherwise: load the MEM inputs and clear hold_valid.
- mem_word = hold_valid ? hold_data : dm_rdata.
- Byte offset = alu_out_w[1:0]. Lane selection is little-endian.
- Extension by reg_write_w:
  - LB: sign-extend byte at offset.
  - LBU: zero-extend byte at offset.
  - LH: sign-extend halfword at offset[1]; offset[0] is ignored, since misalignment is trapped upstream.
  - LHU: zero-extend halfword at offset[1].
  - LW: full word.
  - NOREGWRITE: ext = 0.
- WD3 = mem_to_reg_w ? ext : alu_out_w. Non-load ALU writes use type LW.
- A3 = rd_w; WE3 = reg_write_w.
- Latency: MEM inputs are visible on A3/WD3/WE3 one cycle after the capturing edge. The register-file write then completes on the following negedge.
- rd_m = 0: passed through unchanged; the register file ignores it, and fwd_valid_w=0.
- Reset during stall: everything clears and hold_valid=0.
- Outputs are combinational from registered state and dm_rdata only. There is no path from MEM inputs to outputs.

Optional Feature:
- Macro: WB_INSTRET_EN.
- When defined:
  - Adds output instret  out  64.
  - Counts every cycle in which the WB register holds a non-bubble instruction and stall_w=0.
  - A non-bubble instruction is one loaded while neither flush_w nor rst was asserted; this is tracked by an internal valid bit that is cleared by rst/flush.
  - The counter resets to 0, wraps at 2^64, and is not cleared by flush.
- When not defined: no port and no counter logic.

Decomposition:
- Package riscv_wb_pkg holds:
  - Write-type encoding: NOREGWRITE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5; codes 6-7 behave as NOREGWRITE with ext=0.
  - XLEN and REG_AW defaults.
- One sub-module, load_ext: purely combinational (word, offset, type) -> ext.
- wb_stage holds all sequential state.

Test Plan:
- rst=1 for 2 cycles with nonzero inputs -> WE3=0, A3=0, WD3=0, fwd_valid_w=0.
- LB, offset 3, dm_rdata=0x80FF_1234 -> WD3=0xFFFF_FF80. LBU same word -> 0x0000_0080. LH offset 2 -> 0xFFFF_80FF. LHU offset 0 -> 0x0000_1234.
- ALU write: mem_to_reg_m=0, LW, rd_m=7, alu_out_m=0xDEAD_BEEF -> next cycle A3=7, WD3=0xDEAD_BEEF, fwd_valid_w=1.
- LW load, then stall_w=1 for 3 cycles while dm_rdata changes 0x11111111 -> 0x22222222 -> 0x33333333 -> WD3 stays at the first-cycle value 0x11111111. After release, the next instruction is loaded normally.
- flush_w=1 together with stall_w=1 -> bubble on the next cycle (WE3=0).
- rd_m=0 with LW -> fwd_valid_w=0.
- With WB_INSTRET_EN: 5 valid instructions, 1 flush bubble, 2 stall cycles -> instret=5.

Source files
------------

// File: rtl/riscv_wb_pkg.sv
// Shared write-back definitions: write-type encoding and datapath defaults.
// Optional instret counter in wb_stage is enabled by WB_INSTRET_EN.
package riscv_wb_pkg;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_REG_AW = 5;

  typedef enum logic [2:0] {
    NOREGWRITE = 3'd0,
    LB         = 3'd1,
    LH         = 3'd2,
    LW         = 3'd3,
    LBU        = 3'd4,
    LHU        = 3'd5
  } wr_type_e;

endpackage

// File: rtl/wb_stage_load_ext.sv
// Load-data lane select and sign/zero extension.
// Purely combinational; codes 6-7 yield zero like NOREGWRITE.
module load_ext
  import riscv_wb_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      off,
  input  logic [2:0]      typ,
  output logic [XLEN-1:0] ext
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = word[{off, 3'b000} +: 8];
  assign h = off[1] ? word[31:16] : word[15:0];

  always_comb begin
    ext = '0;
    unique case (1'b1)
      (typ == LB):  ext = {{(XLEN-8){b[7]}}, b};
      (typ == LBU): ext = {{(XLEN-8){1'b0}}, b};
      (typ == LH):  ext = {{(XLEN-16){h[15]}}, h};
      (typ == LHU): ext = {{(XLEN-16){1'b0}}, h};
      (typ == LW):  ext = word;
      default:      ext = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB boundary register, cache-word hold across stalls, write port 3.
// Define WB_INSTRET_EN to add the 64-bit retired-instruction counter.
module wb_stage
  import riscv_wb_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_w,
  input  logic              flush_w,
  input  logic [2:0]        reg_write_m,
  input  logic              mem_to_reg_m,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [XLEN-1:0]   alu_out_m,
  input  logic [XLEN-1:0]   dm_rdata,
  output logic [REG_AW-1:0] A3,
  output logic [XLEN-1:0]   WD3,
  output logic [2:0]        WE3,
  output logic              fwd_valid_w,
  output logic [XLEN-1:0]   fwd_data_w
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]       instret
`endif
);

  logic [2:0]        reg_write_w;
  logic              mem_to_reg_w;
  logic [REG_AW-1:0] rd_w;
  logic [XLEN-1:0]   alu_out_w;
  logic              hold_valid;
  logic [XLEN-1:0]   hold_data;
  logic [XLEN-1:0]   mem_word;
  logic [XLEN-1:0]   ext;

  always_ff @(posedge clk) begin
    if (rst || flush_w) begin
      reg_write_w  <= '0;
      mem_to_reg_w <= 1'b0;
      rd_w         <= '0;
      alu_out_w    <= '0;
      hold_valid   <= 1'b0;
      hold_data    <= '0;
    end else if (stall_w) begin
      // The cache word is only valid on the first stalled cycle.
      if (!hold_valid) begin
        hold_data  <= dm_rdata;
        hold_valid <= 1'b1;
      end
    end else begin
      reg_write_w  <= reg_write_m;
      mem_to_reg_w <= mem_to_reg_m;
      rd_w         <= rd_m;
      alu_out_w    <= alu_out_m;
      hold_valid   <= 1'b0;
    end
  end

  assign mem_word = hold_valid ? hold_data : dm_rdata;

  load_ext #(.XLEN(XLEN)) u_ext (
    .word (mem_word),
    .off  (alu_out_w[1:0]),
    .typ  (reg_write_w),
    .ext  (ext)
  );

  assign A3          = rd_w;
  assign WE3         = reg_write_w;
  assign WD3         = mem_to_reg_w ? ext : alu_out_w;
  assign fwd_valid_w = (reg_write_w != 3'd0) && (rd_w != '0);
  assign fwd_data_w  = WD3;

`ifdef WB_INSTRET_EN
  logic        valid_w;
  logic [63:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_w <= 1'b0;
      cnt     <= '0;
    end else begin
      if (valid_w && !stall_w)
        cnt <= cnt + 64'd1;
      if (flush_w)
        valid_w <= 1'b0;
      else if (!stall_w)
        valid_w <= 1'b1;
    end
  end

  assign instret = cnt;
`endif

endmodule
